// File: rtl/tpu_seq_pkg.sv
// Shared types and constants for the TPU command sequencer: command layout,
// wait modes and FSM states.
package tpu_seq_pkg;

  localparam int CMD_W     = 81;
  localparam int PTR_LSB   = 72;
  localparam int PTR_W     = 9;
  localparam int ADDR_LSB  = 56;
  localparam int ROW_LSB   = 40;
  localparam int COL_LSB   = 24;
  localparam int DIM_W     = 16;
  localparam int TRANS_BIT = 23;
  localparam int PATH_LSB  = 19;
  localparam int PATH_W    = 4;
  localparam int SW_BIT    = 18;
  localparam int MODE_LSB  = 16;
  localparam int MODE_W    = 2;
  localparam int CNT_LSB   = 0;
  localparam int CNT_W     = 16;

  localparam logic [MODE_W-1:0] WM_NONE     = 2'd0;
  localparam logic [MODE_W-1:0] WM_CYCLES   = 2'd1;
  localparam logic [MODE_W-1:0] WM_WRBEATS  = 2'd2;
  localparam logic [MODE_W-1:0] WM_RESERVED = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  typedef struct packed {
    logic [PTR_W-1:0]  ptr_select;
    logic [DIM_W-1:0]  addr;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic              transpose;
    logic [PATH_W-1:0] pathway;
    logic              sw;
    logic [MODE_W-1:0] wait_mode;
    logic [CNT_W-1:0]  wait_count;
  } cmd_t;

  function automatic cmd_t cmd_decode(input logic [CMD_W-1:0] d);
    cmd_t c;
    c.ptr_select = d[PTR_LSB +: PTR_W];
    c.addr       = d[ADDR_LSB +: DIM_W];
    c.row        = d[ROW_LSB +: DIM_W];
    c.col        = d[COL_LSB +: DIM_W];
    c.transpose  = d[TRANS_BIT];
    c.pathway    = d[PATH_LSB +: PATH_W];
    c.sw         = d[SW_BIT];
    c.wait_mode  = d[MODE_LSB +: MODE_W];
    c.wait_count = d[CNT_LSB +: CNT_W];
    return c;
  endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// Host command handshake into the sequencer.
interface tpu_sequencer_if;
  import tpu_seq_pkg::*;

  logic [CMD_W-1:0] cmd_data_in;
  logic             cmd_valid_in;
  logic             cmd_ready_out;

  modport master (output cmd_data_in, cmd_valid_in, input cmd_ready_out);
  modport slave  (input cmd_data_in, cmd_valid_in, output cmd_ready_out);
endinterface

// File: rtl/tpu_seq_fifo.sv
// Command FIFO with flush; pointers carry an extra wrap bit for full/empty.
module tpu_seq_fifo #(
  parameter int CMD_DEPTH = 4,
  parameter int CMD_W     = 81
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] wdata,
  output logic [CMD_W-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(CMD_DEPTH);

  logic [CMD_W-1:0] mem [CMD_DEPTH];
  logic [AW:0]      wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush) mem[wp[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/tpu_sequencer.sv
// Command sequencer for the TPU datapath: issues queued commands to the UB
// read engine / systolic switch / VPU pathway and waits per command's mode.
module tpu_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int CMD_DEPTH            = 4,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  tpu_sequencer_if.slave                  cmd,
  input  logic                            abort_in,
  input  logic [0:SYSTOLIC_ARRAY_WIDTH-1] ub_wr_valid_in,
  output logic                            ub_rd_start_out,
  output logic                            ub_rd_transpose_out,
  output logic [PTR_W-1:0]                ub_ptr_select_out,
  output logic [DIM_W-1:0]                ub_rd_addr_out,
  output logic [DIM_W-1:0]                ub_rd_row_size_out,
  output logic [DIM_W-1:0]                ub_rd_col_size_out,
  output logic [PATH_W-1:0]               vpu_data_pathway_out,
  output logic                            sys_switch_out,
  output logic                            busy_out,
  output logic                            done_out,
  output logic                            error_out
);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e             state;
  logic [CMD_W-1:0]   head_raw;
  cmd_t               head;
  logic               full, empty, push, pop, rdy_en;
  logic [MODE_W-1:0]  mode;
  logic [CNT_W-1:0]   wcnt, cnt, acc;
  logic [WD_W-1:0]    wd;
  logic [CNT_W:0]     beats, sum;
  logic               fin, to;

  assign cmd.cmd_ready_out = rdy_en && !full && !abort_in;
  assign push     = cmd.cmd_valid_in && cmd.cmd_ready_out;
  assign head     = cmd_decode(head_raw);
  assign busy_out = (state != ST_IDLE) || !empty;

  tpu_seq_fifo #(.CMD_DEPTH(CMD_DEPTH), .CMD_W(CMD_W)) u_fifo (
    .clk, .rst, .flush(abort_in), .push, .pop,
    .wdata(cmd.cmd_data_in), .rdata(head_raw), .full, .empty
  );

  // Completion (fin) vs watchdog expiry (to); beats judged on acc + this cycle.
  always_comb begin
    beats = '0;
    for (int i = 0; i < SYSTOLIC_ARRAY_WIDTH; i++)
      beats = beats + (CNT_W+1)'(ub_wr_valid_in[i]);
    sum = {1'b0, acc} + beats;
    fin = 1'b0;
    to  = 1'b0;
    case (state)
      ST_ISSUE: fin = (mode == WM_NONE) || (mode == WM_RESERVED) || (wcnt == '0);
      ST_WAIT: begin
        if (mode == WM_CYCLES)                 fin = (cnt == CNT_W'(1));
        else if (sum >= {1'b0, wcnt})          fin = 1'b1;
        else if (wd == WD_W'(TIMEOUT_CYCLES-1)) to = 1'b1;
      end
      default: ;
    endcase
    pop = !abort_in && !empty && ((state == ST_IDLE) || fin || to);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= ST_IDLE;
      rdy_en               <= 1'b0;
      mode                 <= WM_NONE;
      wcnt                 <= '0;
      cnt                  <= '0;
      acc                  <= '0;
      wd                   <= '0;
      ub_rd_start_out      <= 1'b0;
      ub_rd_transpose_out  <= 1'b0;
      ub_ptr_select_out    <= '0;
      ub_rd_addr_out       <= '0;
      ub_rd_row_size_out   <= '0;
      ub_rd_col_size_out   <= '0;
      vpu_data_pathway_out <= '0;
      sys_switch_out       <= 1'b0;
      done_out             <= 1'b0;
      error_out            <= 1'b0;
    end else begin
      rdy_en          <= 1'b1;
      ub_rd_start_out <= 1'b0;
      sys_switch_out  <= 1'b0;
      done_out        <= 1'b0;
      if (abort_in) begin
        state <= ST_IDLE;
        cnt   <= '0;
        acc   <= '0;
        wd    <= '0;
      end else begin
        done_out <= fin;
        if ((state == ST_ISSUE && mode == WM_RESERVED) || to) error_out <= 1'b1;
        if (fin || to) state <= ST_IDLE;
        if (state == ST_WAIT) begin
          cnt <= cnt - 1'b1;
          acc <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          if (mode == WM_WRBEATS) wd <= wd + 1'b1;
        end
        if (state == ST_ISSUE && !fin) begin
          state <= ST_WAIT;
          cnt   <= wcnt;
          acc   <= '0;
          wd    <= '0;
        end
        // A pop overrides the IDLE return above and latches the new config.
        if (pop) begin
          state                <= ST_ISSUE;
          mode                 <= head.wait_mode;
          wcnt                 <= head.wait_count;
          ub_rd_start_out      <= 1'b1;
          sys_switch_out       <= head.sw;
          ub_rd_transpose_out  <= head.transpose;
          ub_ptr_select_out    <= head.ptr_select;
          ub_rd_addr_out       <= head.addr;
          ub_rd_row_size_out   <= head.row;
          ub_rd_col_size_out   <= head.col;
          vpu_data_pathway_out <= head.pathway;
        end
      end
    end
  end
endmodule
